mux_a_arbiter: RTL and testbench

- Round-robin arbiter that shares the 4-input operand multiplexer (Mux_A) between four requesters.
- Registers a one-hot grant and drives the 2-bit mux select S_A from the grant.
- Sits between the requesting units (fetch, ALU writeback, I/O, debug) and the mux select input.
- Hands ownership directly from one requester to the next with no idle cycle when another request is pending.

---
 rtl/mux_a_arbiter_pkg.sv | 24 ++
 rtl/mux_a_arbiter_rr_pick.sv | 32 +++
 rtl/mux_a_arbiter.sv | 131 +++++++++++++
 tb/tb_mux_a_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_a_arbiter_pkg.sv
// Shared types and constants for the Mux_A round-robin arbiter.
// HOLD_MAX only matters when MUX_A_HOLD_LIMIT_EN is defined.
package mux_a_pkg;

  localparam int NREQ     = 4;
  localparam int SEL_W    = 2;
  localparam int HOLD_MAX = 8;
  localparam int HOLD_W   = $clog2(HOLD_MAX);

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_t;

  function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (oh[i]) idx = SEL_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mux_a_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of (req & mask) searching
// upward from last+1, wrapping modulo NREQ, so last itself ranks lowest.
module rr_pick
  import mux_a_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] last,
  input  logic [NREQ-1:0]  mask,
  output logic [SEL_W-1:0] win,
  output logic             any
);

  logic [NREQ-1:0]  cand;
  logic [SEL_W-1:0] idx;

  // Walk from the lowest priority (offset NREQ == last) to the highest
  // (offset 1) so the final hit is the closest requester after last.
  always_comb begin
    cand = req & mask;
    win  = '0;
    any  = 1'b0;
    idx  = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = last + SEL_W'(k);
      if (cand[idx]) begin
        win = idx;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_a_arbiter.sv
// Round-robin owner arbiter for the Mux_A operand mux; registers the one-hot
// grant and S_A select. Optional hold limit enabled by MUX_A_HOLD_LIMIT_EN.
module mux_a_arbiter
  import mux_a_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  grant,
  output logic [SEL_W-1:0] sel,
`ifdef MUX_A_HOLD_LIMIT_EN
  output logic             preempt,
`endif
  output logic             sel_valid
);

  arb_state_t       state_q, state_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             sel_valid_q, sel_valid_d;
  logic [SEL_W-1:0] last_q, last_d;

  logic [SEL_W-1:0] owner;
  logic [NREQ-1:0]  mask;
  logic [SEL_W-1:0] win;
  logic             any;
  logic             force_rot;

`ifdef MUX_A_HOLD_LIMIT_EN
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              preempt_q, preempt_d;

  // Forced rotation only when the owner still wants the mux and someone waits.
  assign force_rot = (state_q == GRANT) && req[owner] &&
                     (hold_cnt_q == HOLD_W'(HOLD_MAX - 1)) &&
                     (|(req & ~grant_q));
`else
  assign force_rot = 1'b0;
`endif

  assign owner = onehot_to_idx(grant_q);
  assign mask  = force_rot ? ~grant_q : {NREQ{1'b1}};

  rr_pick u_rr_pick (
    .req  (req),
    .last (last_q),
    .mask (mask),
    .win  (win),
    .any  (any)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    sel_d       = sel_q;
    sel_valid_d = sel_valid_q;
    last_d      = last_q;
`ifdef MUX_A_HOLD_LIMIT_EN
    hold_cnt_d  = hold_cnt_q;
    preempt_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (any) begin
          state_d     = GRANT;
          grant_d     = {{(NREQ-1){1'b0}}, 1'b1} << win;
          sel_d       = win;
          sel_valid_d = 1'b1;
          last_d      = win;
`ifdef MUX_A_HOLD_LIMIT_EN
          hold_cnt_d  = '0;
`endif
        end
      end
      GRANT: begin
        if (req[owner] && !force_rot) begin
`ifdef MUX_A_HOLD_LIMIT_EN
          if (hold_cnt_q != HOLD_W'(HOLD_MAX - 1)) hold_cnt_d = hold_cnt_q + 1'b1;
`endif
        end else if (any) begin
          // Direct handover: the next owner takes over on this edge, no bubble.
          grant_d     = {{(NREQ-1){1'b0}}, 1'b1} << win;
          sel_d       = win;
          sel_valid_d = 1'b1;
          last_d      = win;
`ifdef MUX_A_HOLD_LIMIT_EN
          hold_cnt_d  = '0;
          preempt_d   = force_rot;
`endif
        end else begin
          state_d     = IDLE;
          grant_d     = '0;
          sel_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      sel_q       <= '0;
      sel_valid_q <= 1'b0;
      last_q      <= SEL_W'(NREQ - 1);
`ifdef MUX_A_HOLD_LIMIT_EN
      hold_cnt_q  <= '0;
      preempt_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      sel_q       <= sel_d;
      sel_valid_q <= sel_valid_d;
      last_q      <= last_d;
`ifdef MUX_A_HOLD_LIMIT_EN
      hold_cnt_q  <= hold_cnt_d;
      preempt_q   <= preempt_d;
`endif
    end
  end

  assign grant     = grant_q;
  assign sel       = sel_q;
  assign sel_valid = sel_valid_q;
`ifdef MUX_A_HOLD_LIMIT_EN
  assign preempt   = preempt_q;
`endif

endmodule

// File: tb/tb_mux_a_arbiter.sv
// Directed and randomized self-checking bench for mux_a_arbiter.
// The hold-limit scenario runs only when MUX_A_HOLD_LIMIT_EN is defined.
module tb_mux_a_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       sel_valid;
`ifdef MUX_A_HOLD_LIMIT_EN
  logic       preempt;
`endif

  int pass_cnt = 0;
  int check_cnt = 0;

  mux_a_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .grant     (grant),
    .sel       (sel),
`ifdef MUX_A_HOLD_LIMIT_EN
    .preempt   (preempt),
`endif
    .sel_valid (sel_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    tick();
    check_cnt++;
    if ({grant, sel, sel_valid} !== 7'b0000_00_0)
      $display("[TB] FAIL reset_state: got %b expected %b", {grant, sel, sel_valid}, 7'b0000_00_0);
    else pass_cnt++;
    rst_n = 1'b1;
    tick();
    check_cnt++;
    if ({grant, sel, sel_valid} !== 7'b0000_00_0)
      $display("[TB] FAIL idle_after_reset: got %b expected %b", {grant, sel, sel_valid}, 7'b0000_00_0);
    else pass_cnt++;
  endtask

  task automatic test_handover();
    req = 4'b0101;
    tick();
    check_cnt++;
    if ({grant, sel, sel_valid} !== {4'b0001, 2'd0, 1'b1})
      $display("[TB] FAIL handover_first: got %b expected %b", {grant, sel, sel_valid}, {4'b0001, 2'd0, 1'b1});
    else pass_cnt++;
    req = 4'b0100;
    tick();
    check_cnt++;
    if ({grant, sel, sel_valid} !== {4'b0100, 2'd2, 1'b1})
      $display("[TB] FAIL handover_next: got %b expected %b", {grant, sel, sel_valid}, {4'b0100, 2'd2, 1'b1});
    else pass_cnt++;
    req = 4'b0000;
    tick();
    check_cnt++;
    if ({grant, sel, sel_valid} !== {4'b0000, 2'd2, 1'b0})
      $display("[TB] FAIL handover_release: got %b expected %b", {grant, sel, sel_valid}, {4'b0000, 2'd2, 1'b0});
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    logic [1:0] exp_s;
    do_reset();
    req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      exp_s = 2'(k % 4);
      exp_g = 4'b0001 << exp_s;
      check_cnt++;
      if ({grant, sel, sel_valid} !== {exp_g, exp_s, 1'b1})
        $display("[TB] FAIL rr_turn%0d: got %b expected %b", k, {grant, sel, sel_valid}, {exp_g, exp_s, 1'b1});
      else pass_cnt++;
      tick();
      check_cnt++;
      if ({grant, sel, sel_valid} !== {exp_g, exp_s, 1'b1})
        $display("[TB] FAIL rr_hold%0d: got %b expected %b", k, {grant, sel, sel_valid}, {exp_g, exp_s, 1'b1});
      else pass_cnt++;
      req = 4'b1111 & ~exp_g;
      tick();
      req = 4'b1111;
    end
    req = 4'b0000;
    tick();
    check_cnt++;
    if (sel_valid !== 1'b0)
      $display("[TB] FAIL rr_idle: got %b expected %b", sel_valid, 1'b0);
    else pass_cnt++;
  endtask

  task automatic test_single_hold();
    req = 4'b1000;
    for (int c = 0; c < 5; c++) begin
      tick();
      check_cnt++;
      if ({grant, sel, sel_valid} !== {4'b1000, 2'd3, 1'b1})
        $display("[TB] FAIL single_hold%0d: got %b expected %b", c, {grant, sel, sel_valid}, {4'b1000, 2'd3, 1'b1});
      else pass_cnt++;
    end
    req = 4'b0000;
    tick();
    check_cnt++;
    if ({grant, sel, sel_valid} !== {4'b0000, 2'd3, 1'b0})
      $display("[TB] FAIL single_release: got %b expected %b", {grant, sel, sel_valid}, {4'b0000, 2'd3, 1'b0});
    else pass_cnt++;
  endtask

  task automatic test_nonowner_change();
    req = 4'b0001;
    tick();
    req = 4'b0111;
    tick();
    check_cnt++;
    if ({grant, sel, sel_valid} !== {4'b0001, 2'd0, 1'b1})
      $display("[TB] FAIL nonowner_raise: got %b expected %b", {grant, sel, sel_valid}, {4'b0001, 2'd0, 1'b1});
    else pass_cnt++;
    req = 4'b1001;
    tick();
    check_cnt++;
    if ({grant, sel, sel_valid} !== {4'b0001, 2'd0, 1'b1})
      $display("[TB] FAIL nonowner_toggle: got %b expected %b", {grant, sel, sel_valid}, {4'b0001, 2'd0, 1'b1});
    else pass_cnt++;
    req = 4'b0000;
    tick();
  endtask

  task automatic test_fairness();
    do_reset();
    req = 4'b0001;
    tick();
    req = 4'b0000;
    tick();
    req = 4'b0011;
    tick();
    check_cnt++;
    if ({grant, sel, sel_valid} !== {4'b0010, 2'd1, 1'b1})
      $display("[TB] FAIL fair_last_lowest: got %b expected %b", {grant, sel, sel_valid}, {4'b0010, 2'd1, 1'b1});
    else pass_cnt++;
    req = 4'b0000;
    tick();
  endtask

  task automatic test_async_reset();
    req = 4'b0100;
    tick();
    check_cnt++;
    if ({grant, sel, sel_valid} !== {4'b0100, 2'd2, 1'b1})
      $display("[TB] FAIL async_pre: got %b expected %b", {grant, sel, sel_valid}, {4'b0100, 2'd2, 1'b1});
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    check_cnt++;
    if ({grant, sel, sel_valid} !== 7'b0000_00_0)
      $display("[TB] FAIL async_clear: got %b expected %b", {grant, sel, sel_valid}, 7'b0000_00_0);
    else pass_cnt++;
    tick();
    rst_n = 1'b1;
    req = 4'b0010;
    tick();
    check_cnt++;
    if ({grant, sel, sel_valid} !== {4'b0010, 2'd1, 1'b1})
      $display("[TB] FAIL async_release: got %b expected %b", {grant, sel, sel_valid}, {4'b0010, 2'd1, 1'b1});
    else pass_cnt++;
    req = 4'b0000;
    tick();
  endtask

`ifdef MUX_A_HOLD_LIMIT_EN
  task automatic test_hold_limit();
    do_reset();
    req = 4'b0010;
    tick();
    for (int t = 1; t <= 8; t++) begin
      if (t == 3) req = 4'b0110;
      tick();
      check_cnt++;
      if (t < 8 && {grant, preempt} !== {4'b0010, 1'b0})
        $display("[TB] FAIL hold_keep%0d: got %b expected %b", t, {grant, preempt}, {4'b0010, 1'b0});
      else if (t == 8 && {grant, preempt} !== {4'b0100, 1'b1})
        $display("[TB] FAIL hold_preempt: got %b expected %b", {grant, preempt}, {4'b0100, 1'b1});
      else pass_cnt++;
    end
    tick();
    check_cnt++;
    if ({grant, preempt} !== {4'b0100, 1'b0})
      $display("[TB] FAIL hold_pulse_end: got %b expected %b", {grant, preempt}, {4'b0100, 1'b0});
    else pass_cnt++;
    do_reset();
    req = 4'b0010;
    for (int t = 0; t < 20; t++) begin
      tick();
      check_cnt++;
      if ({grant, preempt} !== {4'b0010, 1'b0})
        $display("[TB] FAIL hold_alone%0d: got %b expected %b", t, {grant, preempt}, {4'b0010, 1'b0});
      else pass_cnt++;
    end
    req = 4'b0000;
    tick();
  endtask
`endif

  task automatic test_random();
    logic [3:0] r, g, prev_g;
    int  wcnt[4];
    bit  waiting[4];
    bit  ok;
    int  worst;
    do_reset();
    r = 4'b0000;
    prev_g = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      wcnt[i] = 0;
      waiting[i] = 1'b0;
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      tick();
      g = grant;
      ok = ($countones(g) <= 1) && (sel_valid == (g != 4'b0000)) &&
           (!sel_valid || g == (4'b0001 << sel));
      check_cnt++;
      if (!ok)
        $display("[TB] FAIL rand_onehot cyc %0d: got grant=%b sel=%0d valid=%b expected one-hot grant matching sel", cyc, g, sel, sel_valid);
      else pass_cnt++;
      worst = 0;
      for (int i = 0; i < 4; i++) begin
        if (waiting[i]) begin
          if (g[i]) waiting[i] = 1'b0;
          else if (g != prev_g && g != 4'b0000) wcnt[i]++;
        end
        if (waiting[i] && wcnt[i] > worst) worst = wcnt[i];
      end
      check_cnt++;
      if (worst > 3) begin
        $display("[TB] FAIL rand_fairness cyc %0d: got %0d handovers expected at most 3", cyc, worst);
        for (int i = 0; i < 4; i++) waiting[i] = 1'b0;
      end else pass_cnt++;
      r = r ^ 4'($urandom & $urandom);
      for (int i = 0; i < 4; i++) begin
        if (!r[i]) waiting[i] = 1'b0;
        else if (!waiting[i] && !g[i]) begin
          waiting[i] = 1'b1;
          wcnt[i] = 0;
        end
      end
      prev_g = g;
      req = r;
    end
    req = 4'b0000;
    tick();
  endtask

  initial begin
    test_reset();
    test_handover();
    test_round_robin();
    test_single_hold();
    test_nonowner_change();
    test_fairness();
    test_async_reset();
`ifdef MUX_A_HOLD_LIMIT_EN
    test_hold_limit();
`endif
    test_random();
    $display("[TB] %0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
